// File: rtl/mem_arbiter_pkg.sv
// Shared types for the shared-memory-port arbiter: bus request payload, FSM states, owners.
`timescale 1ns/1ps
package mem_arbiter_pkg;

    typedef logic [31:0] u32;
    typedef logic [15:0] u16;
    typedef logic [3:0]  u4;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] strobe;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of D grants taken while I was waiting; at_limit tells arbitration to favour I.
`timescale 1ns/1ps
module mem_arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // at_limit is registered alongside the count so it tracks cnt_q exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            at_limit <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_limit <= (cnt_d == LIMIT);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single memory port shared by instruction fetch (I) and load/store (D).
// Optional grant statistics ports are built when MEM_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    output logic                  iresp_valid,
    output logic [DATA_W-1:0]     iresp_data,
    input  logic                  dreq_valid,
    input  logic                  dreq_write,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [DATA_W-1:0]     dreq_wdata,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    output logic                  dresp_valid,
    output logic [DATA_W-1:0]     dresp_data,
    output logic                  mreq_valid,
    output logic                  mreq_write,
    output logic [ADDR_W-1:0]     mreq_addr,
    output logic [DATA_W-1:0]     mreq_wdata,
    output logic [DATA_W/8-1:0]   mreq_strobe,
    input  logic                  mreq_ready,
    input  logic                  mresp_valid,
    input  logic [DATA_W-1:0]     mresp_data,
    output logic                  busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_igrants,
    output logic [31:0]           stat_dgrants,
    output logic [15:0]           stat_starve_hits
`endif
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    mem_req_t          req_q, req_d;
    logic              mreq_valid_q, mreq_valid_d;
    logic              iresp_valid_q, iresp_valid_d;
    logic              dresp_valid_q, dresp_valid_d;
    logic [DATA_W-1:0] iresp_data_q, iresp_data_d;
    logic [DATA_W-1:0] dresp_data_q, dresp_data_d;
    logic              busy_q;

    logic grant_i;
    logic grant_d;
    logic d_wins;
    logic at_limit;
    logic deliver;
    logic resp_pulse;

    assign d_wins     = dreq_valid && (!ireq_valid || !at_limit);
    assign resp_pulse = iresp_valid_q || dresp_valid_q;
    assign deliver    = mresp_valid &&
                        (((state_q == REQ) && mreq_ready) || (state_q == WAIT));

    // Next-state, grant and response decode.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_d         = req_q;
        mreq_valid_d  = mreq_valid_q;
        iresp_valid_d = 1'b0;
        dresp_valid_d = 1'b0;
        iresp_data_d  = iresp_data_q;
        dresp_data_d  = dresp_data_q;
        grant_i       = 1'b0;
        grant_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // Hold off during a response pulse: the owner may still show valid that cycle.
                if ((ireq_valid || dreq_valid) && !resp_pulse) begin
                    grant_d      = d_wins;
                    grant_i      = !d_wins;
                    mreq_valid_d = 1'b1;
                    state_d      = REQ;
                    if (d_wins) begin
                        owner_d      = OWN_D;
                        req_d.write  = dreq_write;
                        req_d.addr   = MEM_ADDR_W'(dreq_addr);
                        req_d.wdata  = MEM_DATA_W'(dreq_wdata);
                        req_d.strobe = dreq_write ? MEM_STRB_W'(dreq_strobe) : '1;
                    end else begin
                        owner_d      = OWN_I;
                        req_d.write  = 1'b0;
                        req_d.addr   = MEM_ADDR_W'(ireq_addr);
                        req_d.wdata  = '0;
                        req_d.strobe = '1;
                    end
                end
            end
            REQ: begin
                if (mreq_ready) begin
                    mreq_valid_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                state_d = WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            state_d = IDLE;
            if (owner_q == OWN_I) begin
                iresp_valid_d = 1'b1;
                iresp_data_d  = mresp_data;
            end else begin
                dresp_valid_d = 1'b1;
                dresp_data_d  = mresp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            req_q         <= '0;
            mreq_valid_q  <= 1'b0;
            iresp_valid_q <= 1'b0;
            dresp_valid_q <= 1'b0;
            iresp_data_q  <= '0;
            dresp_data_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            req_q         <= req_d;
            mreq_valid_q  <= mreq_valid_d;
            iresp_valid_q <= iresp_valid_d;
            dresp_valid_q <= dresp_valid_d;
            iresp_data_q  <= iresp_data_d;
            dresp_data_q  <= dresp_data_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (grant_d && ireq_valid),
        .clr      (grant_i || (grant_d && !ireq_valid)),
        .at_limit (at_limit)
    );

    assign mreq_valid  = mreq_valid_q;
    assign mreq_write  = req_q.write;
    assign mreq_addr   = ADDR_W'(req_q.addr);
    assign mreq_wdata  = DATA_W'(req_q.wdata);
    assign mreq_strobe = STRB_W'(req_q.strobe);
    assign iresp_valid = iresp_valid_q;
    assign iresp_data  = iresp_data_q;
    assign dresp_valid = dresp_valid_q;
    assign dresp_data  = dresp_data_q;
    assign busy        = busy_q;

`ifdef MEM_ARB_STATS_EN
    u32 igrants_q;
    u32 dgrants_q;
    u16 starve_hits_q;

    // Saturating grant counters; an I grant with D also pending was forced by the starve limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            igrants_q     <= '0;
            dgrants_q     <= '0;
            starve_hits_q <= '0;
        end else begin
            if (grant_i && (igrants_q != '1)) begin
                igrants_q <= igrants_q + 32'd1;
            end
            if (grant_d && (dgrants_q != '1)) begin
                dgrants_q <= dgrants_q + 32'd1;
            end
            if (grant_i && dreq_valid && (starve_hits_q != '1)) begin
                starve_hits_q <= starve_hits_q + 16'd1;
            end
        end
    end

    assign stat_igrants     = igrants_q;
    assign stat_dgrants     = dgrants_q;
    assign stat_starve_hits = starve_hits_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic vs a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                ireq_valid;
    logic [ADDR_W-1:0]   ireq_addr;
    logic                iresp_valid;
    logic [DATA_W-1:0]   iresp_data;
    logic                dreq_valid;
    logic                dreq_write;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [DATA_W-1:0]   dreq_wdata;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic                dresp_valid;
    logic [DATA_W-1:0]   dresp_data;
    logic                mreq_valid;
    logic                mreq_write;
    logic [ADDR_W-1:0]   mreq_addr;
    logic [DATA_W-1:0]   mreq_wdata;
    logic [DATA_W/8-1:0] mreq_strobe;
    logic                mreq_ready;
    logic                mresp_valid;
    logic [DATA_W-1:0]   mresp_data;
    logic                busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]         stat_igrants;
    logic [31:0]         stat_dgrants;
    logic [15:0]         stat_starve_hits;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Transaction-level model state
    int starve = 0;
    int m_igr  = 0;
    int m_dgr  = 0;
    int m_hits = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .dreq_valid  (dreq_valid),
        .dreq_write  (dreq_write),
        .dreq_addr   (dreq_addr),
        .dreq_wdata  (dreq_wdata),
        .dreq_strobe (dreq_strobe),
        .dresp_valid (dresp_valid),
        .dresp_data  (dresp_data),
        .mreq_valid  (mreq_valid),
        .mreq_write  (mreq_write),
        .mreq_addr   (mreq_addr),
        .mreq_wdata  (mreq_wdata),
        .mreq_strobe (mreq_strobe),
        .mreq_ready  (mreq_ready),
        .mresp_valid (mresp_valid),
        .mresp_data  (mresp_data),
        .busy        (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_igrants     (stat_igrants),
        .stat_dgrants     (stat_dgrants),
        .stat_starve_hits (stat_starve_hits)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // 1 = D wins under the priority/starvation rule.
    function automatic bit model_pick(input bit iv, input bit dv);
        return dv && (!iv || (starve < int'(MAX_WAIT)));
    endfunction

    function automatic void model_grant(input bit iv, input bit dv, input bit od);
        if (od) begin
            m_dgr++;
            starve = iv ? ((starve < int'(MAX_WAIT)) ? starve + 1 : starve) : 0;
        end else begin
            m_igr++;
            if (dv) m_hits++;
            starve = 0;
        end
    endfunction

    function automatic void model_reset();
        starve = 0;
        m_igr  = 0;
        m_dgr  = 0;
        m_hits = 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mreq_valid"}, mreq_valid, 0);
        chk({tag, "_mreq_write"}, mreq_write, 0);
        chk({tag, "_mreq_addr"}, mreq_addr, 0);
        chk({tag, "_mreq_wdata"}, mreq_wdata, 0);
        chk({tag, "_mreq_strobe"}, mreq_strobe, 0);
        chk({tag, "_resp_valids"}, {iresp_valid, dresp_valid}, 0);
        chk({tag, "_iresp_data"}, iresp_data, 0);
        chk({tag, "_dresp_data"}, dresp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Runs one transaction: requests must already be driven, od is the expected owner (1 = D).
    task automatic run_txn(input bit od, input int rdy_dly, input int rsp_dly, input bit same,
                           input logic [DATA_W-1:0] rdata, input bit noise, input bit drop_mid,
                           input bit rel);
        logic                e_write;
        logic [ADDR_W-1:0]   e_addr;
        logic [DATA_W-1:0]   e_wdata;
        logic [DATA_W/8-1:0] e_strobe;
        bit                  got;
        e_write  = od ? dreq_write : 1'b0;
        e_addr   = od ? dreq_addr : ireq_addr;
        e_wdata  = od ? dreq_wdata : '0;
        e_strobe = (od && dreq_write) ? dreq_strobe : '1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = mreq_valid;
        end
        chk("grant_valid", mreq_valid, 1);
        chk("req_write", mreq_write, e_write);
        chk("req_addr", mreq_addr, e_addr);
        chk("req_wdata", mreq_wdata, e_wdata);
        chk("req_strobe", mreq_strobe, e_strobe);
        chk("req_busy", busy, 1);
        if (drop_mid) begin
            if (od) dreq_valid = 1'b0;
            else    ireq_valid = 1'b0;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            mreq_ready  = 1'b0;
            mresp_valid = noise && ($urandom_range(0, 1) == 1);
            mresp_data  = $urandom;
            step();
            mresp_valid = 1'b0;
            chk("hold_valid", mreq_valid, 1);
            chk("hold_write", mreq_write, e_write);
            chk("hold_addr", mreq_addr, e_addr);
            chk("hold_wdata", mreq_wdata, e_wdata);
            chk("hold_strobe", mreq_strobe, e_strobe);
            chk("hold_no_resp", {iresp_valid, dresp_valid}, 0);
        end
        mreq_ready  = 1'b1;
        mresp_valid = same;
        mresp_data  = rdata;
        step();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        chk("accept_drop_valid", mreq_valid, 0);
        if (!same) begin
            chk("wait_no_resp", {iresp_valid, dresp_valid}, 0);
            chk("wait_busy", busy, 1);
            for (int i = 0; i < rsp_dly; i++) begin
                step();
                chk("wait_no_resp", {iresp_valid, dresp_valid}, 0);
                chk("wait_busy", busy, 1);
            end
            mresp_valid = 1'b1;
            mresp_data  = rdata;
            step();
            mresp_valid = 1'b0;
        end
        chk("iresp_pulse", iresp_valid, !od);
        chk("dresp_pulse", dresp_valid, od);
        chk("resp_data", od ? dresp_data : iresp_data, rdata);
        chk("resp_busy_low", busy, 0);
        chk("resp_mreq_low", mreq_valid, 0);
        if (rel) begin
            if (od) dreq_valid = 1'b0;
            else    ireq_valid = 1'b0;
        end
        step();
        chk("pulse_one_cycle", {iresp_valid, dresp_valid}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit                ord [10];
        bit                od;
        bit                ip;
        bit                dp;

        ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset       = 1'b1;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        dreq_valid  = 1'b0;
        dreq_write  = 1'b0;
        dreq_addr   = '0;
        dreq_wdata  = '0;
        dreq_strobe = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
        step();
        step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        step();
        chk_all_zero("after_reset");

        // Fairness: both requesters held continuously
        ireq_valid  = 1'b1;
        ireq_addr   = 32'h0040_0010;
        dreq_valid  = 1'b1;
        dreq_write  = 1'b0;
        dreq_addr   = 32'h1001_0000;
        dreq_wdata  = 32'h0;
        dreq_strobe = 4'h0;
        for (int k = 0; k < 10; k++) begin
            model_grant(1'b1, 1'b1, ord[k]);
            run_txn(ord[k], 0, 0, 1'b0, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
`ifdef MEM_ARB_STATS_EN
        chk("stat_dgrants_fair", stat_dgrants, 8);
        chk("stat_igrants_fair", stat_igrants, 2);
        chk("stat_starve_fair", stat_starve_hits, 2);
`endif

        // Single fetch, ready on first REQ cycle, response two cycles after ready
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0040_0000;
        od = model_pick(1'b1, 1'b0);
        model_grant(1'b1, 1'b0, od);
        run_txn(od, 0, 1, 1'b0, 32'h2008_0005, 1'b0, 1'b0, 1'b1);
        chk("fetch_idle_busy", busy, 0);

        // Store with ready delayed 3 cycles
        dreq_valid  = 1'b1;
        dreq_write  = 1'b1;
        dreq_addr   = 32'h1001_0004;
        dreq_wdata  = 32'hDEAD_BEEF;
        dreq_strobe = 4'b0011;
        od = model_pick(1'b0, 1'b1);
        model_grant(1'b0, 1'b1, od);
        run_txn(od, 3, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Ready and response in the same cycle
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0040_0004;
        od = model_pick(1'b1, 1'b0);
        model_grant(1'b1, 1'b0, od);
        run_txn(od, 1, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);

        // Reset during WAIT, then a stray response in IDLE
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0040_0008;
        step();
        chk("rst_test_grant", mreq_valid, 1);
        mreq_ready = 1'b1;
        step();
        mreq_ready = 1'b0;
        chk("rst_test_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        ireq_valid = 1'b0;
        model_reset();
        step();
        reset = 1'b0;
        step();
        mresp_valid = 1'b1;
        mresp_data  = 32'hBAD0_BAD0;
        step();
        mresp_valid = 1'b0;
        chk_all_zero("stray_resp");
        step();
        chk_all_zero("stray_resp_next");
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0040_000C;
        od = model_pick(1'b1, 1'b0);
        model_grant(1'b1, 1'b0, od);
        run_txn(od, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        ip = 1'b0;
        dp = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!ip && ($urandom_range(0, 2) != 0)) begin
                ireq_valid = 1'b1;
                ireq_addr  = $urandom;
                ip = 1'b1;
            end
            if (!dp && ($urandom_range(0, 2) != 0)) begin
                dreq_valid  = 1'b1;
                dreq_write  = 1'($urandom_range(0, 1));
                dreq_addr   = $urandom;
                dreq_wdata  = $urandom;
                dreq_strobe = 4'($urandom_range(0, 15));
                dp = 1'b1;
            end
            if (!ip && !dp) begin
                ireq_valid = 1'b1;
                ireq_addr  = $urandom;
                ip = 1'b1;
            end
            od = model_pick(ip, dp);
            model_grant(ip, dp, od);
            run_txn(od, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                    $urandom, 1'b1, ($urandom_range(0, 7) == 0), 1'b1);
            if (od) dp = 1'b0;
            else    ip = 1'b0;
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        step();
        chk("final_idle", busy, 0);
`ifdef MEM_ARB_STATS_EN
        chk("stat_igrants_model", stat_igrants, 64'(m_igr));
        chk("stat_dgrants_model", stat_dgrants, 64'(m_dgr));
        chk("stat_starve_model", stat_starve_hits, 64'(m_hits));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
